video_pattern_gen: RTL and testbench

// - Parametrised RGB video timing + test-pattern source; replaces the fixed-format BMP driver in the DVI benches.
// - Produces vsync/hsync/data_valid plus PPC pixels per clock, with runtime-selectable pattern.
// - Feeds the RGB-to-DVI transmitter or a dvi2rgb loopback check; frame counter and markers aid scoreboarding.

---
 rtl/video_pattern_gen.sv | 201 ++++++++++++++++++++
 tb/tb_video_pattern_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/video_pattern_gen.sv
// Video timing + test-pattern source: syncs, data_valid, markers and PPC RGB pixels per clock.
// Latency: every output is registered and lags the internal h/v counters by exactly one clock.
// Backpressure: none (free-running source); enable=0 only stops the stream at the end of the current frame.
module video_pattern_gen #(
    parameter int H_ACTIVE  = 1920,
    parameter int H_FP      = 88,
    parameter int H_SYNC    = 44,
    parameter int H_BP      = 148,
    parameter int V_ACTIVE  = 1080,
    parameter int V_FP      = 4,
    parameter int V_SYNC    = 5,
    parameter int V_BP      = 36,
    parameter int PPC       = 1,
    parameter     HSYNC_POL = "NEGATIVE",
    parameter     VSYNC_POL = "NEGATIVE"
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       pattern_sel,
    input  logic [23:0]      solid_rgb,
    output logic             vsync,
    output logic             hsync,
    output logic             data_valid,
    output logic [8*PPC-1:0] data_r,
    output logic [8*PPC-1:0] data_g,
    output logic [8*PPC-1:0] data_b,
    output logic             sof,
    output logic             eol,
    output logic [15:0]      frame_cnt,
    output logic             busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    // Bar width in pixels; (x*8)/H_ACTIVE == x/BAR_PIX because H_ACTIVE is a multiple of 8.
    localparam int BAR_PIX = H_ACTIVE / 8;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - PPC);
    localparam logic [HW-1:0] H_STEP = HW'(PPC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    // Active level of each sync; the idle level is its complement.
    localparam logic HS_ACT = (HSYNC_POL == "POSITIVE");
    localparam logic VS_ACT = (VSYNC_POL == "POSITIVE");

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic [31:0]     h32;
    logic [31:0]     v32;
    logic            running;
    logic            last_beat;
    logic            frame_start;
    logic            in_active;
    logic            in_hsync;
    logic            in_vsync;
    logic            y_b4;
    logic [1:0]      sel_q;
    logic [1:0]      eff_sel;
    logic [23:0]     solid_q;
    logic [23:0]     eff_solid;
    logic [23:0]     pix_nxt [PPC];

    assign h32         = 32'(h_cnt);
    assign v32         = 32'(v_cnt);
    assign running     = (state != IDLE);
    assign busy        = running;
    assign last_beat   = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign frame_start = running && (h_cnt == '0) && (v_cnt == '0);
    assign in_active   = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
    assign in_hsync    = (h32 >= H_ACTIVE + H_FP) && (h32 < H_ACTIVE + H_FP + H_SYNC);
    assign in_vsync    = (v32 >= V_ACTIVE + V_FP) && (v32 < V_ACTIVE + V_FP + V_SYNC);
    assign y_b4        = ((v32 & 32'h10) != 32'h0);

    // On the first beat of a frame the live selection is used directly, so the
    // sampled value already applies to pixel (0,0); the held copy covers the rest.
    assign eff_sel   = frame_start ? pattern_sel : sel_q;
    assign eff_solid = frame_start ? solid_rgb   : solid_q;

    // One pixel of the selected pattern at column x.
    function automatic logic [23:0] pix_at(input logic [1:0]  sel,
                                           input logic [23:0] solid,
                                           input logic [31:0] x,
                                           input logic        yb4);
        logic [2:0]  bar;
        logic [7:0]  xl;
        logic        xb4;
        logic [23:0] p;
        bar = 3'd0;
        for (int b = 1; b < 8; b++) begin
            if (x >= 32'(b * BAR_PIX)) bar = bar + 3'd1;
        end
        xl  = 8'(x);
        xb4 = ((x & 32'h10) != 32'h0);
        // Bar order white,yellow,cyan,green,magenta,red,blue,black:
        // red is on when bar[1]=0, green when bar[2]=0, blue when bar[0]=0.
        case (sel)
            2'd0:    p = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
            2'd1:    p = {xl, xl, xl};
            2'd2:    p = solid;
            default: p = (xb4 ^ yb4) ? 24'hFFFFFF : 24'h000000;
        endcase
        return p;
    endfunction

    // Per-lane pixel values for the beat the counters currently point at.
    always_comb begin
        for (int k = 0; k < PPC; k++) begin
            pix_nxt[k] = pix_at(eff_sel, eff_solid, h32 + 32'(k), y_b4);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: DRAIN keeps counting until the frame's last beat unless re-enabled.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = DRAIN;
            DRAIN: begin
                if (enable)         state_nxt = RUN;
                else if (last_beat) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Raster counters: held at the origin while idle, free-running otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!running) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + H_STEP;
        end
    end

    // Pattern selection is captured at frame start and held for the frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q   <= 2'd0;
            solid_q <= 24'h0;
        end else if (frame_start) begin
            sel_q   <= pattern_sel;
            solid_q <= solid_rgb;
        end
    end

    // Completed-frame counter, stepped on the last beat of every emitted frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                     frame_cnt <= 16'h0;
        else if (running && last_beat)  frame_cnt <= frame_cnt + 16'h1;
    end

    // Registered video outputs, one clock behind the counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync      <= ~HS_ACT;
            vsync      <= ~VS_ACT;
            data_valid <= 1'b0;
            sof        <= 1'b0;
            eol        <= 1'b0;
            data_r     <= '0;
            data_g     <= '0;
            data_b     <= '0;
        end else begin
            hsync      <= (running && in_hsync) ? HS_ACT : ~HS_ACT;
            vsync      <= (running && in_vsync) ? VS_ACT : ~VS_ACT;
            data_valid <= running && in_active;
            sof        <= frame_start && in_active;
            eol        <= running && in_active && (h32 == H_ACTIVE - PPC);
            for (int k = 0; k < PPC; k++) begin
                data_r[8*k +: 8] <= (running && in_active) ? pix_nxt[k][23:16] : 8'h00;
                data_g[8*k +: 8] <= (running && in_active) ? pix_nxt[k][15:8]  : 8'h00;
                data_b[8*k +: 8] <= (running && in_active) ? pix_nxt[k][7:0]   : 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen: PPC=1 timing/patterns/stop/reset and a PPC=4 ramp line.
// Outputs are sampled 1 time unit after each rising edge; inputs are driven at the same point.
// A single linear initial block drives the stimulus; checks are immediate assertions.
module tb_video_pattern_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        enable4;
    logic [1:0]  pattern_sel;
    logic [1:0]  sel4;
    logic [23:0] solid_rgb;

    logic        vs1, hs1, dv1, sof1, eol1, busy1;
    logic [7:0]  r1, g1, b1;
    logic [15:0] fc1;

    logic        vs4, hs4, dv4, sof4, eol4, busy4;
    logic [31:0] r4, g4, b4;
    logic [15:0] fc4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    video_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(4),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PPC(1), .HSYNC_POL("NEGATIVE"), .VSYNC_POL("NEGATIVE")
    ) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
        .solid_rgb(solid_rgb), .vsync(vs1), .hsync(hs1), .data_valid(dv1),
        .data_r(r1), .data_g(g1), .data_b(b1), .sof(sof1), .eol(eol1),
        .frame_cnt(fc1), .busy(busy1)
    );

    video_pattern_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(4), .H_BP(4),
        .V_ACTIVE(4),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PPC(4), .HSYNC_POL("NEGATIVE"), .VSYNC_POL("NEGATIVE")
    ) dut4 (
        .clk(clk), .reset(reset), .enable(enable4), .pattern_sel(sel4),
        .solid_rgb(solid_rgb), .vsync(vs4), .hsync(hs4), .data_valid(dv4),
        .data_r(r4), .data_g(g4), .data_b(b4), .sof(sof4), .eol(eol4),
        .frame_cnt(fc4), .busy(busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] bar_rgb(input int i);
        case (i)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Expected dut1 bundle for sample n of the main run (n=0 is the first beat).
    // Frames 0/1/2 use bars/ramp/solid 0x123456; frame 2 is the last (drained) frame.
    function automatic logic [63:0] exp_main(input int n);
        int h, v, f;
        logic bz, dv, hs, vs, sf, el;
        logic [23:0] rgb;
        logic [15:0] fc;
        h  = n % 24;
        v  = (n / 24) % 8;
        f  = n / 192;
        fc = (n >= 575) ? 16'd3 : 16'((n + 1) / 192);
        if (n > 575) begin
            bz = 0; dv = 0; hs = 1; vs = 1; sf = 0; el = 0; rgb = 24'h0;
        end else begin
            bz = (n < 575);
            dv = (h < 16) && (v < 4);
            hs = !((h >= 18) && (h < 22));
            vs = !((v >= 5) && (v < 7));
            sf = (n % 192 == 0);
            el = dv && (h == 15);
            if (!dv)         rgb = 24'h0;
            else if (f == 0) rgb = bar_rgb(h / 2);
            else if (f == 1) rgb = {3{8'(h)}};
            else             rgb = 24'h123456;
        end
        return {18'd0, bz, dv, hs, vs, sf, el, rgb, fc};
    endfunction

    function automatic logic [63:0] obs1();
        return {18'd0, busy1, dv1, hs1, vs1, sof1, eol1, r1, g1, b1, fc1};
    endfunction

    localparam logic [63:0] IDLE_FC0 = {18'd0, 6'b001100, 24'h0, 16'h0};

    initial begin
        reset       = 1'b0;
        enable      = 1'b0;
        enable4     = 1'b0;
        pattern_sel = 2'd0;
        sel4        = 2'd1;
        solid_rgb   = 24'h0;

        // Reset state
        tick(); tick(); tick();
        chk("reset_state", obs1(), IDLE_FC0);
        chk("reset_state4", {59'd0, busy4, dv4, hs4, vs4, sof4}, {59'd0, 5'b00110});
        reset = 1'b1;
        tick(); tick();
        chk("idle_no_enable", obs1(), IDLE_FC0);

        // Start: RUN entry, then first beat one clock later
        enable = 1'b1;
        tick();
        chk("run_entry_busy_dv", {62'd0, busy1, dv1}, {62'd0, 2'b10});
        tick();
        for (int n = 0; n < 616; n++) begin
            chk($sformatf("main_n%0d", n), obs1(), exp_main(n));
            if (n == 100) pattern_sel = 2'd1;
            if (n == 300) begin
                pattern_sel = 2'd2;
                solid_rgb   = 24'h123456;
            end
            if (n == 400) solid_rgb = 24'hABCDEF;
            if (n == 444) enable = 1'b0;
            tick();
        end

        // Restart, then async reset in the middle of an active line
        enable = 1'b1;
        tick();
        tick();
        chk("restart_sof", {32'd0, sof1, dv1, 6'd0, r1, g1, b1}, {32'd0, 2'b11, 6'd0, 24'hABCDEF});
        for (int i = 0; i < 29; i++) tick();
        chk("pre_reset_active", {63'd0, dv1}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_mid_line", obs1(), IDLE_FC0);
        tick();
        tick();
        chk("held_in_reset", obs1(), IDLE_FC0);
        reset = 1'b1;
        tick();
        chk("post_reset_entry", {62'd0, busy1, dv1}, {62'd0, 2'b10});
        tick();
        chk("post_reset_first", {30'd0, sof1, dv1, r1, g1, b1, fc1},
            {30'd0, 2'b11, 24'hABCDEF, 16'h0});
        enable = 1'b0;

        // PPC=4 ramp: four beats of four lanes, eol on beat 3
        enable4 = 1'b1;
        tick();
        tick();
        chk("ppc4_first_sof", {62'd0, sof4, dv4}, {62'd0, 2'b11});
        for (int b = 0; b < 4; b++) begin
            logic [31:0] lane;
            lane = {8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)};
            chk($sformatf("ppc4_beat%0d_rgb", b), {r4, g4}, {lane, lane});
            chk($sformatf("ppc4_beat%0d_b_eol", b), {31'd0, eol4, b4}, {31'd0, (b == 3), lane});
            tick();
        end
        chk("ppc4_blank_after_line", {31'd0, dv4, r4}, 64'd0);
        enable4 = 1'b0;

        // Both instances drain their frames and stop
        for (int i = 0; i < 200; i++) tick();
        chk("ppc4_drained", {47'd0, busy4, fc4}, {47'd0, 1'b0, 16'd1});
        chk("ppc1_drained", {46'd0, busy1, sof1, fc1}, {46'd0, 2'b00, 16'd1});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
